mem_arb: RTL and testbench

- Two-master arbiter that shares the single data-memory port in front of mem_xbar.
- Master 0 is the core load/store port; master 1 is a secondary requester (debug loader or DMA).
- Grants at most one access per cycle and steers writes downstream.
- Returns synchronous read data to the owning master with a fixed latency.
- Enforces a starvation bound for master 1.

---
 rtl/mem_arb.sv | 168 ++++++++++++++++
 tb/tb_mem_arb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: two-master arbiter for the shared data-memory port.
// Master 0 (core load/store) and master 1 (debug loader / DMA) compete for
// one downstream access per cycle. Read data returns RD_LATENCY cycles after
// the grant and goes only to the master that issued the read.
// Optional build macro MEM_ARB_RR_EN: fair round-robin instead of fixed
// priority with a MAX_WAIT starvation bound for master 1.
module mem_arb #(
  parameter int MAX_WAIT   = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_m0_req,
  input  logic [29:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  input  logic [3:0]  i_m0_mask,
  input  logic        i_m0_wren,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_data,
  input  logic        i_m1_req,
  input  logic [29:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  input  logic [3:0]  i_m1_mask,
  input  logic        i_m1_wren,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_data,
  output logic [29:0] o_mem_addr,
  output logic [31:0] o_mem_data,
  output logic [3:0]  o_mem_mask,
  output logic        o_mem_wren,
  input  logic [31:0] i_mem_data
);

  logic       w_gnt0;
  logic       w_gnt1;
  logic [3:0] r_wait_cnt;
  logic       w_push_valid;
  logic       w_push_id;
  logic       w_out_valid;
  logic       w_out_id;

`ifdef MEM_ARB_RR_EN
  // Most recently granted master; reset to 1 so master 0 wins first contention.
  logic r_last;

  // Round-robin grant: on contention the master that was not granted last wins.
  // Grants are masked by rst so every output is 0 while reset is held.
  always_comb begin
    w_gnt1 = !rst && i_m1_req && (!i_m0_req || !r_last);
    w_gnt0 = !rst && i_m0_req && !w_gnt1;
  end

  // Pointer follows every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_gnt1) begin
      r_last <= 1'b1;
    end else if (w_gnt0) begin
      r_last <= 1'b0;
    end
  end

  // Starvation counter is not needed under round-robin; keep it parked at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end
`else
  logic w_force;

  // Fixed priority to master 0, overridden once master 1 has waited MAX_WAIT cycles.
  always_comb begin
    w_force = i_m1_req && (r_wait_cnt == 4'(MAX_WAIT));
    w_gnt1  = !rst && i_m1_req && (w_force || !i_m0_req);
    w_gnt0  = !rst && i_m0_req && !w_gnt1;
  end

  // Count consecutive denied cycles of master 1, saturating at MAX_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
    end else if (!i_m1_req || w_gnt1) begin
      r_wait_cnt <= 4'd0;
    end else if (r_wait_cnt != 4'(MAX_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end
`endif

  assign o_m0_gnt = w_gnt0;
  assign o_m1_gnt = w_gnt1;

  // Steer the granted master's payload downstream; all zero when idle so no
  // stray write can ever reach memory.
  always_comb begin
    o_mem_addr = 30'd0;
    o_mem_data = 32'd0;
    o_mem_mask = 4'd0;
    o_mem_wren = 1'b0;
    if (w_gnt1) begin
      o_mem_addr = i_m1_addr;
      o_mem_data = i_m1_data;
      o_mem_mask = i_m1_mask;
      o_mem_wren = i_m1_wren;
    end else if (w_gnt0) begin
      o_mem_addr = i_m0_addr;
      o_mem_data = i_m0_data;
      o_mem_mask = i_m0_mask;
      o_mem_wren = i_m0_wren;
    end
  end

  // Entry for the return pipeline: valid only for a granted read, tagged with its owner.
  always_comb begin
    w_push_valid = (w_gnt0 && !i_m0_wren) || (w_gnt1 && !i_m1_wren);
    w_push_id    = w_gnt1;
  end

  // RD_LATENCY-deep shift register tracking which master owns each returning word.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
      logic r_valid;
      logic r_id;
      if (gi == 0) begin : g_head
        // First stage captures the access granted this cycle.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_valid <= 1'b0;
            r_id    <= 1'b0;
          end else begin
            r_valid <= w_push_valid;
            r_id    <= w_push_id;
          end
        end
      end else begin : g_tail
        // Later stages simply delay the previous stage by one cycle.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_valid <= 1'b0;
            r_id    <= 1'b0;
          end else begin
            r_valid <= g_pipe[gi-1].r_valid;
            r_id    <= g_pipe[gi-1].r_id;
          end
        end
      end
    end
  endgenerate

  assign w_out_valid = g_pipe[RD_LATENCY-1].r_valid;
  assign w_out_id    = g_pipe[RD_LATENCY-1].r_id;

  // Route returning data only to its owner; the other master sees zeros.
  always_comb begin
    o_m0_rvalid = w_out_valid && !w_out_id;
    o_m1_rvalid = w_out_valid && w_out_id;
    o_m0_data   = o_m0_rvalid ? i_mem_data : 32'd0;
    o_m1_data   = o_m1_rvalid ? i_mem_data : 32'd0;
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb. Instance dut uses RD_LATENCY=1,
// instance dut2 uses RD_LATENCY=2; both share the same request stimulus.
module tb_mem_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wren, m1_req, m1_wren;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata, mem_rdata;
  logic [3:0]  m0_mask, m1_mask;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_wren;
  logic [31:0] m0_rdata, m1_rdata, mem_wdata;
  logic [29:0] mem_addr;
  logic [3:0]  mem_mask;

  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_wren;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_wdata;
  logic [29:0] b_mem_addr;
  logic [3:0]  b_mem_mask;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arb #(.MAX_WAIT(4), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_data(m0_wdata), .i_m0_mask(m0_mask),
    .i_m0_wren(m0_wren), .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_data(m0_rdata),
    .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_data(m1_wdata), .i_m1_mask(m1_mask),
    .i_m1_wren(m1_wren), .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_data(m1_rdata),
    .o_mem_addr(mem_addr), .o_mem_data(mem_wdata), .o_mem_mask(mem_mask),
    .o_mem_wren(mem_wren), .i_mem_data(mem_rdata)
  );

  mem_arb #(.MAX_WAIT(4), .RD_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst),
    .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_data(m0_wdata), .i_m0_mask(m0_mask),
    .i_m0_wren(m0_wren), .o_m0_gnt(b_m0_gnt), .o_m0_rvalid(b_m0_rvalid), .o_m0_data(b_m0_rdata),
    .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_data(m1_wdata), .i_m1_mask(m1_mask),
    .i_m1_wren(m1_wren), .o_m1_gnt(b_m1_gnt), .o_m1_rvalid(b_m1_rvalid), .o_m1_data(b_m1_rdata),
    .o_mem_addr(b_mem_addr), .o_mem_data(b_mem_wdata), .o_mem_mask(b_mem_mask),
    .o_mem_wren(b_mem_wren), .i_mem_data(mem_rdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_wren = 1'b0; m0_addr = '0; m0_wdata = '0; m0_mask = '0;
    m1_req = 1'b0; m1_wren = 1'b0; m1_addr = '0; m1_wdata = '0; m1_mask = '0;
    mem_rdata = '0;
  endtask

  task automatic test_reset();
    logic [4:0] outs;
    idle_inputs();
    rst = 1'b1;
    m0_req = 1'b1; m0_addr = 30'h5;
    next_cycle();
    next_cycle();
    #4;
    outs = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wren};
    checks++;
    if (outs !== 5'b0 || mem_addr !== 30'd0) begin
      failures++;
      $display("FAIL reset_hold: flags=%b addr=%h required flags=00000 addr=0", outs, mem_addr);
    end
    // release reset, grant a read, then reset while the return is in flight
    next_cycle();
    rst = 1'b0;
    mem_rdata = 32'h0000_0055;
    #4;
    checks++;
    if (m0_gnt !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_gnt: m0_gnt=%b required 1", m0_gnt);
    end
    next_cycle();
    #1;
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h55) begin
      failures++;
      $display("FAIL reset_pre_rvalid: rvalid=%b data=%h required 1/00000055", m0_rvalid, m0_rdata);
    end
    rst = 1'b1;
    #1;
    outs = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wren};
    checks++;
    if (outs !== 5'b0 || mem_addr !== 30'd0 || m0_rdata !== 32'd0 || b_m0_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: flags=%b addr=%h data=%h b_rvalid=%b required all 0",
               outs, mem_addr, m0_rdata, b_m0_rvalid);
    end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #4;
      outs = {m0_rvalid, m1_rvalid, b_m0_rvalid, b_m1_rvalid, m0_gnt};
      checks++;
      if (outs !== 5'b0) begin
        failures++;
        $display("FAIL reset_no_rvalid[%0d]: flags=%b required 00000", i, outs);
      end
      next_cycle();
    end
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    m0_req = 1'b1; m0_wren = 1'b0; m0_addr = 30'h10;
    #4;
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || mem_addr !== 30'h10 || mem_wren !== 1'b0) begin
      failures++;
      $display("FAIL read_grant: gnt0=%b gnt1=%b addr=%h wren=%b required 1/0/10/0",
               m0_gnt, m1_gnt, mem_addr, mem_wren);
    end
    next_cycle();
    idle_inputs();
    mem_rdata = 32'hDEADBEEF;
    #4;
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read_return: rvalid=%b data=%h required 1/deadbeef", m0_rvalid, m0_rdata);
    end
    checks++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 32'd0 || mem_addr !== 30'd0) begin
      failures++;
      $display("FAIL read_other: m1_rvalid=%b m1_data=%h mem_addr=%h required 0/0/0",
               m1_rvalid, m1_rdata, mem_addr);
    end
    next_cycle();
    #4;
    checks++;
    if (m0_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL read_single_pulse: rvalid=%b required 0", m0_rvalid);
    end
    next_cycle();
    $display("test_single_read done");
  endtask

  task automatic test_write();
    m1_req = 1'b1; m1_wren = 1'b1; m1_addr = 30'h3; m1_wdata = 32'h12345678; m1_mask = 4'b0011;
    #4;
    checks++;
    if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || mem_wren !== 1'b1 || mem_addr !== 30'h3 ||
        mem_wdata !== 32'h12345678 || mem_mask !== 4'b0011) begin
      failures++;
      $display("FAIL write_steer: gnt1=%b gnt0=%b wren=%b addr=%h data=%h mask=%b required 1/0/1/3/12345678/0011",
               m1_gnt, m0_gnt, mem_wren, mem_addr, mem_wdata, mem_mask);
    end
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      #4;
      checks++;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || b_m1_rvalid !== 1'b0 || mem_wren !== 1'b0) begin
        failures++;
        $display("FAIL write_no_rvalid[%0d]: rv0=%b rv1=%b b_rv1=%b wren=%b required 0",
                 i, m0_rvalid, m1_rvalid, b_m1_rvalid, mem_wren);
      end
      next_cycle();
    end
    $display("test_write done");
  endtask

  task automatic test_arbitration();
    logic exp1;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    m0_req = 1'b1; m0_addr = 30'h100;
    m1_req = 1'b1; m1_addr = 30'h200;
    for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_RR_EN
      exp1 = (i % 2) == 1;
`else
      exp1 = (i % 5) == 4;
`endif
      #4;
      checks++;
      if (m1_gnt !== exp1 || m0_gnt !== !exp1 || mem_addr !== (exp1 ? 30'h200 : 30'h100)) begin
        failures++;
        $display("FAIL arb_cycle[%0d]: gnt0=%b gnt1=%b addr=%h required gnt1=%b", i, m0_gnt, m1_gnt,
                 mem_addr, exp1);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();
    $display("test_arbitration done");
  endtask

  task automatic test_interleaved();
    logic        exp_v0, exp_v1;
    logic [31:0] exp_d0, exp_d1;
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      mem_rdata = 32'hC0DE_0000 | 32'(i);
      if (i < 4) begin
        if (i % 2 == 0) begin
          m0_req = 1'b1; m0_addr = 30'(16 + i);
        end else begin
          m1_req = 1'b1; m1_addr = 30'(32 + i);
        end
      end
      exp_v0 = (i >= 2) && ((i - 2) % 2 == 0);
      exp_v1 = (i >= 2) && ((i - 2) % 2 == 1);
      exp_d0 = exp_v0 ? (32'hC0DE_0000 | 32'(i)) : 32'd0;
      exp_d1 = exp_v1 ? (32'hC0DE_0000 | 32'(i)) : 32'd0;
      #4;
      checks++;
      if (b_m0_rvalid !== exp_v0 || b_m1_rvalid !== exp_v1 || b_m0_rdata !== exp_d0 ||
          b_m1_rdata !== exp_d1) begin
        failures++;
        $display("FAIL interleave[%0d]: rv0=%b rv1=%b d0=%h d1=%b%h required %b %b %h %h", i,
                 b_m0_rvalid, b_m1_rvalid, b_m0_rdata, 1'b0, b_m1_rdata, exp_v0, exp_v1, exp_d0, exp_d1);
      end
      if (i < 4) begin
        checks++;
        if (b_m0_gnt !== (i % 2 == 0) || b_m1_gnt !== (i % 2 == 1)) begin
          failures++;
          $display("FAIL interleave_gnt[%0d]: gnt0=%b gnt1=%b", i, b_m0_gnt, b_m1_gnt);
        end
      end
      next_cycle();
    end
    idle_inputs();
    $display("test_interleaved done");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_arbitration();
    test_interleaved();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
